mem_ctrl: RTL

Memory controller and RAM for the 32-bit datapath, sitting directly upstream of the memory data register. It accepts read/write requests from the control unit, takes the address from the MAR and write data from the MDR, and models a word-addressed RAM with a parameterised number of wait states. For reads it returns the word on `Mdatain`, which feeds the MDR's input mux. Completion uses a four-phase request/done handshake.

---
 rtl/mem_ctrl_if.sv | 21 ++
 rtl/mem_ctrl.sv | 89 ++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// Request/response bus between the control unit (master) and mem_ctrl (slave).
interface mem_ctrl_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] Mdatain;
  logic        mem_done;
  logic        busy;
  logic        err;

  modport master (
    output read, write, address, wdata,
    input  Mdatain, mem_done, busy, err
  );

  modport slave (
    input  read, write, address, wdata,
    output Mdatain, mem_done, busy, err
  );
endinterface

// File: rtl/mem_ctrl.sv
// Word-addressed RAM with a wait-state counter and a four-phase
// request/done handshake toward the control unit.
module mem_ctrl #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input logic      clk,
  input logic      clr,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  logic [31:0]       ram [DEPTH];
  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              is_write;
  logic              any_req;
  logic              bad_req;

  // Any request level is seen; conflicting levels or a high address bit
  // turns it into an error that never touches the array.
  assign any_req = bus.read | bus.write;
  assign bad_req = (bus.read & bus.write) | (|bus.address[31:ADDR_W]);

  // Control FSM with registered handshake outputs and read data.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      is_write     <= 1'b0;
      bus.Mdatain  <= '0;
      bus.mem_done <= 1'b0;
      bus.busy     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            bus.busy <= 1'b1;
            if (bad_req) begin
              state        <= DONE;
              bus.mem_done <= 1'b1;
              bus.err      <= 1'b1;
            end else begin
              state    <= WAIT;
              addr_q   <= bus.address[ADDR_W-1:0];
              wdata_q  <= bus.wdata;
              is_write <= bus.write;
              cnt      <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        ACCESS: begin
          if (!is_write) bus.Mdatain <= ram[addr_q];
          state        <= DONE;
          bus.mem_done <= 1'b1;
          bus.err      <= 1'b0;
        end
        DONE: begin
          // Wait for the requester to drop both levels; a new request is
          // only looked at once back in IDLE.
          if (!any_req) begin
            state        <= IDLE;
            bus.mem_done <= 1'b0;
            bus.err      <= 1'b0;
            bus.busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array write port; contents survive clr and are uninitialised.
  always_ff @(posedge clk) begin
    if (state == ACCESS && is_write) ram[addr_q] <= wdata_q;
  end
endmodule
